// File: rtl/alu.sv
// MIPS-style ALU with branch resolution, HI/LO registers, a single-cycle multiplier
// and a 32-iteration restoring divider that stalls the pipeline via exception 0x80.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_op,
  input  logic        check_overflow,
  input  logic [31:0] pc_linear_next,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] alu_const,
  output logic [31:0] alu_out,
  output logic [31:0] br_target,
  output logic        br_enable,
  output logic [7:0]  exception
);

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDU = 6'h01, OP_SUB  = 6'h02, OP_SUBU = 6'h03,
    OP_AND  = 6'h04, OP_OR   = 6'h05, OP_XOR  = 6'h06, OP_NOR  = 6'h07,
    OP_SLT  = 6'h08, OP_SLTU = 6'h09, OP_SLL  = 6'h0A, OP_SRL  = 6'h0B,
    OP_SRA  = 6'h0C, OP_LUI  = 6'h0D,
    OP_BEQ  = 6'h10, OP_BNE  = 6'h11, OP_BLEZ = 6'h12, OP_BGTZ = 6'h13,
    OP_BLTZ = 6'h14, OP_BGEZ = 6'h15, OP_J    = 6'h16, OP_JAL  = 6'h17,
    OP_JR   = 6'h18, OP_JALR = 6'h19,
    OP_MULT = 6'h20, OP_MULTU = 6'h21, OP_DIV = 6'h22, OP_DIVU = 6'h23,
    OP_MFHI = 6'h24, OP_MFLO = 6'h25, OP_MTHI = 6'h26, OP_MTLO = 6'h27
  } op_e;

  logic [31:0] r_hi, r_lo;
  logic        r_busy, r_done;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem, r_quo, r_dvs, r_dvd;
  logic        r_neg_q, r_neg_r, r_dz;

  logic [31:0] w_sum, w_diff, w_br_off, w_cond_tgt;
  logic        w_add_ovf, w_sub_ovf;
  logic        w_is_div, w_signed_div, w_hilo_op, w_stall, w_valid, w_ovf;
  logic [31:0] w_abs_rs, w_abs_rt;
  logic [63:0] w_prod_s, w_prod_u;
  logic [32:0] w_rem_sh, w_sub;
  logic        w_ge;
  logic [31:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;

  assign w_sum      = rs_val + rt_val;
  assign w_diff     = rs_val - rt_val;
  assign w_add_ovf  = (rs_val[31] == rt_val[31]) && (w_sum[31] != rs_val[31]);
  assign w_sub_ovf  = (rs_val[31] != rt_val[31]) && (w_diff[31] != rs_val[31]);
  assign w_br_off   = alu_const << 2;
  assign w_cond_tgt = pc_linear_next + w_br_off;

  assign w_is_div     = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign w_signed_div = (alu_op == OP_DIV);
  assign w_hilo_op    = (alu_op == OP_MFHI) || (alu_op == OP_MFLO) || (alu_op == OP_MTHI) ||
                        (alu_op == OP_MTLO) || (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign w_stall      = (w_is_div && !r_done) || (w_hilo_op && r_busy);

  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Divider works on magnitudes; signs are reapplied on the final iteration.
  assign w_abs_rs = (w_signed_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign w_abs_rt = (w_signed_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_sub    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = !w_sub[32];
  assign w_rem_nx = w_ge ? w_sub[31:0] : w_rem_sh[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};
  assign w_q_fin  = r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
  assign w_r_fin  = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;

  always_comb begin
    alu_out   = 32'd0;
    br_target = pc_linear_next;
    br_enable = 1'b0;
    w_ovf     = 1'b0;
    w_valid   = 1'b1;
    case (alu_op)
      OP_ADD:   begin alu_out = w_sum;  w_ovf = check_overflow && w_add_ovf; end
      OP_ADDU:  alu_out = w_sum;
      OP_SUB:   begin alu_out = w_diff; w_ovf = check_overflow && w_sub_ovf; end
      OP_SUBU:  alu_out = w_diff;
      OP_AND:   alu_out = rs_val & rt_val;
      OP_OR:    alu_out = rs_val | rt_val;
      OP_XOR:   alu_out = rs_val ^ rt_val;
      OP_NOR:   alu_out = ~(rs_val | rt_val);
      OP_SLT:   alu_out = {31'd0, $signed(rs_val) < $signed(rt_val)};
      OP_SLTU:  alu_out = {31'd0, rs_val < rt_val};
      OP_SLL:   alu_out = rt_val << rs_val[4:0];
      OP_SRL:   alu_out = rt_val >> rs_val[4:0];
      OP_SRA:   alu_out = $signed(rt_val) >>> rs_val[4:0];
      OP_LUI:   alu_out = rt_val << 16;
      OP_BEQ:   begin br_target = w_cond_tgt; br_enable = (rs_val == rt_val); end
      OP_BNE:   begin br_target = w_cond_tgt; br_enable = (rs_val != rt_val); end
      OP_BLEZ:  begin br_target = w_cond_tgt; br_enable = rs_val[31] || (rs_val == 32'd0); end
      OP_BGTZ:  begin br_target = w_cond_tgt; br_enable = !rs_val[31] && (rs_val != 32'd0); end
      OP_BLTZ:  begin br_target = w_cond_tgt; br_enable = rs_val[31]; end
      OP_BGEZ:  begin br_target = w_cond_tgt; br_enable = !rs_val[31]; end
      OP_J:     begin br_target = {pc_linear_next[31:28], alu_const[25:0], 2'b00}; br_enable = 1'b1; end
      OP_JAL:   begin
        br_target = {pc_linear_next[31:28], alu_const[25:0], 2'b00};
        br_enable = 1'b1;
        alu_out   = pc_linear_next;
      end
      OP_JR:    begin br_target = rs_val; br_enable = 1'b1; end
      OP_JALR:  begin br_target = rs_val; br_enable = 1'b1; alu_out = pc_linear_next; end
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: ;
      OP_MFHI:  alu_out = r_hi;
      OP_MFLO:  alu_out = r_lo;
      default:  w_valid = 1'b0;
    endcase
    if (!w_valid)     exception = 8'h02;
    else if (w_stall) exception = 8'h80;
    else if (w_ovf)   exception = 8'h01;
    else              exception = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 5'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_dvd   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        // HI/LO writers issued now are blocked; only the divider owns HI/LO.
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_lo   <= r_dz ? 32'hFFFF_FFFF : w_q_fin;
          r_hi   <= r_dz ? r_dvd : w_r_fin;
        end
      end else if (w_is_div && !r_done) begin
        r_busy  <= 1'b1;
        r_cnt   <= 5'd0;
        r_rem   <= 32'd0;
        r_quo   <= w_abs_rs;
        r_dvs   <= w_abs_rt;
        r_dvd   <= rs_val;
        r_neg_q <= w_signed_div && (rs_val[31] ^ rt_val[31]);
        r_neg_r <= w_signed_div && rs_val[31];
        r_dz    <= (rt_val == 32'd0);
      end else begin
        case (alu_op)
          OP_MULT:  {r_hi, r_lo} <= w_prod_s;
          OP_MULTU: {r_hi, r_lo} <= w_prod_u;
          OP_MTHI:  r_hi <= rs_val;
          OP_MTLO:  r_lo <= rs_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: each driven op pushes its expected outputs, which are
// popped and compared once the combinational outputs settle.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  alu_op = 6'h24;
  logic        check_overflow = 1'b0;
  logic [31:0] pc_linear_next = 32'd0, rs_val = 32'd0, rt_val = 32'd0, alu_const = 32'd0;
  logic [31:0] alu_out, br_target;
  logic        br_enable;
  logic [7:0]  exception;

  alu dut (.clk(clk), .rst(rst), .alu_op(alu_op), .check_overflow(check_overflow),
           .pc_linear_next(pc_linear_next), .rs_val(rs_val), .rt_val(rt_val),
           .alu_const(alu_const), .alu_out(alu_out), .br_target(br_target),
           .br_enable(br_enable), .exception(exception));

  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'h00, ADDU = 6'h01, SUB = 6'h02, SUBU = 6'h03, AND_ = 6'h04,
    OR_ = 6'h05, XOR_ = 6'h06, NOR_ = 6'h07, SLT = 6'h08, SLTU = 6'h09, SLL = 6'h0A,
    SRL = 6'h0B, SRA = 6'h0C, LUI = 6'h0D, BEQ = 6'h10, BNE = 6'h11, BLEZ = 6'h12,
    BGTZ = 6'h13, BLTZ = 6'h14, BGEZ = 6'h15, J = 6'h16, JAL = 6'h17, JR = 6'h18,
    JALR = 6'h19, MULT = 6'h20, MULTU = 6'h21, DIV = 6'h22, DIVU = 6'h23, MFHI = 6'h24,
    MFLO = 6'h25, MTHI = 6'h26, MTLO = 6'h27;

  typedef struct {
    string nm; logic [5:0] op; logic [31:0] rs, rt, k, pc; logic ck;
    logic [31:0] eo, et; logic ee; logic [7:0] ex;
  } row_t;
  typedef struct { string nm; logic [72:0] v; } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic row_t mk(string nm, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                              logic [31:0] k, logic [31:0] pc, logic ck, logic [31:0] eo,
                              logic [31:0] et, logic ee, logic [7:0] ex);
    row_t r;
    r.nm = nm; r.op = op; r.rs = rs; r.rt = rt; r.k = k; r.pc = pc; r.ck = ck;
    r.eo = eo; r.et = et; r.ee = ee; r.ex = ex;
    return r;
  endfunction

  task automatic drive(input row_t r);
    @(negedge clk);
    alu_op = r.op; rs_val = r.rs; rt_val = r.rt; alu_const = r.k;
    pc_linear_next = r.pc; check_overflow = r.ck;
    exp_q.push_back('{r.nm, {r.eo, r.et, r.ee, r.ex}});
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rows.push_back(mk("rst_hi", MFHI, 0, 0, 0, 32'h100, 0, 32'h0, 32'h100, 0, 8'h00));
    rows.push_back(mk("rst_lo", MFLO, 0, 0, 0, 32'h100, 0, 32'h0, 32'h100, 0, 8'h00));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  task automatic test_arith();
    row_t rows[$];
    exp_t e;
    logic [31:0] a, b;
    rows.push_back(mk("add_ovf",  ADD,  32'h7FFFFFFF, 1, 0, 32'h1000, 1, 32'h80000000, 32'h1000, 0, 8'h01));
    rows.push_back(mk("addu_ovf", ADDU, 32'h7FFFFFFF, 1, 0, 32'h1000, 1, 32'h80000000, 32'h1000, 0, 8'h00));
    rows.push_back(mk("add_nock", ADD,  32'h7FFFFFFF, 1, 0, 32'h1000, 0, 32'h80000000, 32'h1000, 0, 8'h00));
    rows.push_back(mk("sub_ovf",  SUB,  32'h80000000, 1, 0, 32'h1000, 1, 32'h7FFFFFFF, 32'h1000, 0, 8'h01));
    rows.push_back(mk("subu_ovf", SUBU, 32'h80000000, 1, 0, 32'h1000, 1, 32'h7FFFFFFF, 32'h1000, 0, 8'h00));
    rows.push_back(mk("sub_neg",  SUB,  5, 7, 0, 32'h1000, 1, 32'hFFFFFFFE, 32'h1000, 0, 8'h00));
    rows.push_back(mk("slt_neg",  SLT,  32'hFFFFFFFF, 1, 0, 32'h1000, 0, 1, 32'h1000, 0, 8'h00));
    rows.push_back(mk("sltu_big", SLTU, 32'hFFFFFFFF, 1, 0, 32'h1000, 0, 0, 32'h1000, 0, 8'h00));
    rows.push_back(mk("slt_pos",  SLT,  1, 32'hFFFFFFFF, 0, 32'h1000, 0, 0, 32'h1000, 0, 8'h00));
    rows.push_back(mk("sltu_sml", SLTU, 1, 32'hFFFFFFFF, 0, 32'h1000, 0, 1, 32'h1000, 0, 8'h00));
    for (int n = 0; n < 4; n++) begin
      a = $urandom; b = $urandom;
      rows.push_back(mk("addu_rnd", ADDU, a, b, 0, 32'h1000, 1, a + b, 32'h1000, 0, 8'h00));
      rows.push_back(mk("sub_rnd",  SUB,  a, b, 0, 32'h1000, 0, a - b, 32'h1000, 0, 8'h00));
    end
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  task automatic test_logic_shift();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("and", AND_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h1000, 0, 32'hF000F000, 32'h1000, 0, 0));
    rows.push_back(mk("or",  OR_,  32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h1000, 0, 32'hFFF0FFF0, 32'h1000, 0, 0));
    rows.push_back(mk("xor", XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h1000, 0, 32'h0FF00FF0, 32'h1000, 0, 0));
    rows.push_back(mk("nor", NOR_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h1000, 0, 32'h000F000F, 32'h1000, 0, 0));
    rows.push_back(mk("sll31", SLL, 32'h3F, 1, 0, 32'h1000, 0, 32'h80000000, 32'h1000, 0, 0));
    rows.push_back(mk("srl4",  SRL, 32'h24, 32'h80000000, 0, 32'h1000, 0, 32'h08000000, 32'h1000, 0, 0));
    rows.push_back(mk("sra4",  SRA, 32'h24, 32'h80000000, 0, 32'h1000, 0, 32'hF8000000, 32'h1000, 0, 0));
    rows.push_back(mk("sra0",  SRA, 0, 32'h80000000, 0, 32'h1000, 0, 32'h80000000, 32'h1000, 0, 0));
    rows.push_back(mk("lui",   LUI, 0, 32'h1234, 0, 32'h1000, 0, 32'h12340000, 32'h1000, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  task automatic test_branch_jump();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("beq_t",  BEQ,  5, 5, 32'hFFFFFFFF, 32'h3004, 0, 0, 32'h3000, 1, 0));
    rows.push_back(mk("bne_nt", BNE,  5, 5, 32'hFFFFFFFF, 32'h3004, 0, 0, 32'h3000, 0, 0));
    rows.push_back(mk("bne_t",  BNE,  5, 6, 32'hFFFFFFFF, 32'h3004, 0, 0, 32'h3000, 1, 0));
    rows.push_back(mk("beq_fw", BEQ,  0, 0, 4, 32'h100, 0, 0, 32'h110, 1, 0));
    rows.push_back(mk("blez_0", BLEZ, 0, 0, 4, 32'h100, 0, 0, 32'h110, 1, 0));
    rows.push_back(mk("blez_1", BLEZ, 1, 0, 4, 32'h100, 0, 0, 32'h110, 0, 0));
    rows.push_back(mk("bgtz_0", BGTZ, 0, 0, 4, 32'h100, 0, 0, 32'h110, 0, 0));
    rows.push_back(mk("bgtz_1", BGTZ, 1, 0, 4, 32'h100, 0, 0, 32'h110, 1, 0));
    rows.push_back(mk("bltz_m", BLTZ, 32'hFFFFFFFF, 0, 4, 32'h100, 0, 0, 32'h110, 1, 0));
    rows.push_back(mk("bltz_0", BLTZ, 0, 0, 4, 32'h100, 0, 0, 32'h110, 0, 0));
    rows.push_back(mk("bgez_0", BGEZ, 0, 0, 4, 32'h100, 0, 0, 32'h110, 1, 0));
    rows.push_back(mk("bgez_m", BGEZ, 32'h80000000, 0, 4, 32'h100, 0, 0, 32'h110, 0, 0));
    rows.push_back(mk("jal",    JAL,  0, 0, 32'h0C00, 32'h3008, 0, 32'h3008, 32'h3000, 1, 0));
    rows.push_back(mk("j",      J,    0, 0, 32'h03FFFFFF, 32'h40000010, 0, 0, 32'h4FFFFFFC, 1, 0));
    rows.push_back(mk("j_hi",   J,    0, 0, 32'hFFFFFFFF, 32'hF0000000, 0, 0, 32'hFFFFFFFC, 1, 0));
    rows.push_back(mk("jr",     JR,   32'h1234, 0, 0, 32'h500, 0, 0, 32'h1234, 1, 0));
    rows.push_back(mk("jalr",   JALR, 32'h8000, 0, 0, 32'h500, 0, 32'h500, 32'h8000, 1, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  task automatic test_invalid();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("inv_3f", 6'h3F, 1, 1, 0, 32'h2000, 1, 0, 32'h2000, 0, 8'h02));
    rows.push_back(mk("inv_0e", 6'h0E, 1, 1, 0, 32'h2000, 1, 0, 32'h2000, 0, 8'h02));
    rows.push_back(mk("inv_1a", 6'h1A, 1, 1, 0, 32'h2000, 0, 0, 32'h2000, 0, 8'h02));
    rows.push_back(mk("inv_28", 6'h28, 1, 1, 0, 32'h2000, 0, 0, 32'h2000, 0, 8'h02));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  // Each row is applied across one rising edge, so writes land before the next row.
  task automatic test_mult_hilo();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("multu",   MULTU, 32'hFFFFFFFF, 2, 0, 32'h40, 0, 0, 32'h40, 0, 0));
    rows.push_back(mk("multu_hi", MFHI, 0, 0, 0, 32'h40, 0, 1, 32'h40, 0, 0));
    rows.push_back(mk("multu_lo", MFLO, 0, 0, 0, 32'h40, 0, 32'hFFFFFFFE, 32'h40, 0, 0));
    rows.push_back(mk("mult",    MULT, 32'hFFFFFFFD, 5, 0, 32'h40, 0, 0, 32'h40, 0, 0));
    rows.push_back(mk("mult_hi", MFHI, 0, 0, 0, 32'h40, 0, 32'hFFFFFFFF, 32'h40, 0, 0));
    rows.push_back(mk("mult_lo", MFLO, 0, 0, 0, 32'h40, 0, 32'hFFFFFFF1, 32'h40, 0, 0));
    rows.push_back(mk("mthi",    MTHI, 32'hABCD, 0, 0, 32'h40, 0, 0, 32'h40, 0, 0));
    rows.push_back(mk("mtlo",    MTLO, 32'h55, 0, 0, 32'h40, 0, 0, 32'h40, 0, 0));
    rows.push_back(mk("mthi_rd", MFHI, 0, 0, 0, 32'h40, 0, 32'hABCD, 32'h40, 0, 0));
    rows.push_back(mk("mtlo_rd", MFLO, 0, 0, 0, 32'h40, 0, 32'h55, 32'h40, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  // Divide held for 34 samples: 33 stalled, then the done cycle; then read LO/HI.
  task automatic test_div();
    row_t rows[$];
    exp_t e;
    logic [5:0]  ops[5]  = '{DIV, DIV, DIVU, DIV, DIVU};
    logic [31:0] dvd[5]  = '{32'hFFFFFFF9, 32'h80000000, 32'h1234, 32'hFFFFFFFB, 100};
    logic [31:0] dvs[5]  = '{2, 32'hFFFFFFFF, 0, 0, 7};
    logic [31:0] elo[5]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 14};
    logic [31:0] ehi[5]  = '{32'hFFFFFFFF, 0, 32'h1234, 32'hFFFFFFFB, 2};
    for (int c = 0; c < 5; c++) begin
      for (int t = 0; t < 34; t++)
        rows.push_back(mk($sformatf("div%0d_t%0d", c, t), ops[c], dvd[c], dvs[c], 0, 32'h60, 0,
                          0, 32'h60, 0, (t < 33) ? 8'h80 : 8'h00));
      rows.push_back(mk($sformatf("div%0d_lo", c), MFLO, 0, 0, 0, 32'h60, 0, elo[c], 32'h60, 0, 0));
      rows.push_back(mk($sformatf("div%0d_hi", c), MFHI, 0, 0, 0, 32'h60, 0, ehi[c], 32'h60, 0, 0));
    end
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  // HI/LO writers issued during a divide stall and are dropped.
  task automatic test_busy_block();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("blk_div", DIVU, 100, 7, 0, 32'h70, 0, 0, 32'h70, 0, 8'h80));
    for (int t = 0; t < 32; t++)
      rows.push_back(mk($sformatf("blk_mthi%0d", t), (t < 16) ? MTHI : MULTU, 32'hDEAD, 3, 0,
                        32'h70, 0, 0, 32'h70, 0, 8'h80));
    rows.push_back(mk("blk_hi", MFHI, 0, 0, 0, 32'h70, 0, 2, 32'h70, 0, 0));
    rows.push_back(mk("blk_lo", MFLO, 0, 0, 0, 32'h70, 0, 14, 32'h70, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    row_t rows[$];
    exp_t e;
    for (int t = 0; t < 6; t++)
      drive(mk("mid_div", DIV, 100, 7, 0, 32'h80, 0, 0, 32'h80, 0, 8'h80));
    #1; e = exp_q.pop_front(); checks++;
    if ({alu_out, br_target, br_enable, exception} !== e.v) begin
      errors++;
      $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
               alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b1; alu_op = MFHI;
    @(negedge clk); rst = 1'b0;
    rows.push_back(mk("mid_rst_hi", MFHI, 0, 0, 0, 32'h80, 0, 0, 32'h80, 0, 0));
    rows.push_back(mk("mid_rst_lo", MFLO, 0, 0, 0, 32'h80, 0, 0, 32'h80, 0, 0));
    rows.push_back(mk("mid_rst_mt", MTLO, 9, 0, 0, 32'h80, 0, 0, 32'h80, 0, 0));
    rows.push_back(mk("mid_rst_rd", MFLO, 0, 0, 0, 32'h80, 0, 9, 32'h80, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1; e = exp_q.pop_front(); checks++;
      if ({alu_out, br_target, br_enable, exception} !== e.v) begin
        errors++;
        $display("FAIL %s got out=%h tgt=%h en=%b exc=%h exp out=%h tgt=%h en=%b exc=%h", e.nm,
                 alu_out, br_target, br_enable, exception, e.v[72:41], e.v[40:9], e.v[8], e.v[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_branch_jump();
    test_invalid();
    test_mult_hilo();
    test_div();
    test_busy_block();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
